// File: rtl/turn_signal_pkg.sv
// Shared types and helpers for the sequential turn-signal controller.
// The brake override is built in when TURN_SIGNAL_BRAKE_EN is defined.
package turn_signal_pkg;

    typedef enum logic [2:0] {
        TS_IDLE    = 3'd0,
        TS_LEFT    = 3'd1,
        TS_RIGHT   = 3'd2,
        TS_HAZ_ON  = 3'd3,
        TS_HAZ_OFF = 3'd4
    } ts_state_t;

    localparam int unsigned TS_MAX_LAMPS = 16;

    // Thermometer code with the k lowest bits set; callers keep the low LAMPS bits.
    function automatic logic [TS_MAX_LAMPS-1:0] ts_thermo(input logic [4:0] k);
        logic [TS_MAX_LAMPS:0] ones;
        ones = (17'd1 << k) - 17'd1;
        return ones[TS_MAX_LAMPS-1:0];
    endfunction

endpackage

// File: rtl/turn_signal_seq_step_prescaler.sv
// Free-running step-rate divider: tick is high on one cycle out of every DIV.
// Used by turn_signal_seq (TURN_SIGNAL_BRAKE_EN has no effect here).
module step_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;

    // Next count: wrap to zero after the tick cycle.
    always_comb begin
        cnt_s = cnt_r;
        if (cnt_r == LAST) begin
            cnt_s = '0;
        end else begin
            cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Counter register; never restarted by requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_s;
        end
    end

    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/turn_signal_seq.sv
// Sequential turn-signal controller, LAMPS lamps per side, stepping every STEP_DIV cycles.
// Define TURN_SIGNAL_BRAKE_EN to add the brake port and its lamp override.
module turn_signal_seq
    import turn_signal_pkg::*;
#(
    parameter int LAMPS    = 3,
    parameter int STEP_DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
`ifdef TURN_SIGNAL_BRAKE_EN
    input  logic             brake,
`endif
    output logic [LAMPS-1:0] l,
    output logic [LAMPS-1:0] r
);

    localparam int KW = $clog2(LAMPS + 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);
    localparam logic [KW-1:0] K_LAST = KW'(LAMPS);

    ts_state_t   state_r;
    ts_state_t   state_s;
    logic [KW-1:0] k_r;
    logic [KW-1:0] k_s;
    logic          tick_s;
    logic          haz_req_s;

    logic [TS_MAX_LAMPS-1:0] thermo_full_s;
    logic [LAMPS-1:0]        thermo_s;
    logic [LAMPS-1:0]        fill_s;
    logic [LAMPS-1:0]        l_s;
    logic [LAMPS-1:0]        r_s;
    logic                    unused_thermo_s;

    step_prescaler #(.DIV(STEP_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    // Both turn levels together count as a hazard request, never as a turn.
    assign haz_req_s = hazard | (left & right);

`ifdef TURN_SIGNAL_BRAKE_EN
    assign fill_s = {LAMPS{brake}};
`else
    assign fill_s = '0;
`endif

    // State register; only advances on prescaler ticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= TS_IDLE;
            k_r     <= K_ONE;
        end else if (tick_s) begin
            state_r <= state_s;
            k_r     <= k_s;
        end else begin
            state_r <= state_r;
            k_r     <= k_r;
        end
    end

    // Next-state logic; k parks at 1 outside a sequence so every run restarts innermost.
    always_comb begin
        state_s = state_r;
        k_s     = K_ONE;
        case (state_r)
            TS_IDLE: begin
                if (haz_req_s) begin
                    state_s = TS_HAZ_ON;
                end else if (left) begin
                    state_s = TS_LEFT;
                end else if (right) begin
                    state_s = TS_RIGHT;
                end else begin
                    state_s = TS_IDLE;
                end
            end
            TS_LEFT: begin
                if (haz_req_s) begin
                    state_s = TS_HAZ_ON;
                end else if (!left || (k_r == K_LAST)) begin
                    state_s = TS_IDLE;
                end else begin
                    state_s = TS_LEFT;
                    k_s     = k_r + K_ONE;
                end
            end
            TS_RIGHT: begin
                if (haz_req_s) begin
                    state_s = TS_HAZ_ON;
                end else if (!right || (k_r == K_LAST)) begin
                    state_s = TS_IDLE;
                end else begin
                    state_s = TS_RIGHT;
                    k_s     = k_r + K_ONE;
                end
            end
            TS_HAZ_ON: begin
                if (haz_req_s) begin
                    state_s = TS_HAZ_OFF;
                end else begin
                    state_s = TS_IDLE;
                end
            end
            TS_HAZ_OFF: begin
                if (haz_req_s) begin
                    state_s = TS_HAZ_ON;
                end else begin
                    state_s = TS_IDLE;
                end
            end
            default: begin
                state_s = TS_IDLE;
            end
        endcase
    end

    assign thermo_full_s   = ts_thermo(5'(k_r));
    assign thermo_s        = thermo_full_s[LAMPS-1:0];
    assign unused_thermo_s = ^thermo_full_s;

    // Moore lamp decode; an idle side takes the brake fill (zero when brake is absent).
    always_comb begin
        l_s = '0;
        r_s = '0;
        case (state_r)
            TS_IDLE: begin
                l_s = fill_s;
                r_s = fill_s;
            end
            TS_LEFT: begin
                l_s = thermo_s;
                r_s = fill_s;
            end
            TS_RIGHT: begin
                l_s = fill_s;
                r_s = thermo_s;
            end
            TS_HAZ_ON: begin
                l_s = '1;
                r_s = '1;
            end
            TS_HAZ_OFF: begin
                l_s = '0;
                r_s = '0;
            end
            default: begin
                l_s = '0;
                r_s = '0;
            end
        endcase
    end

    assign l = l_s;
    assign r = r_s;

endmodule

// File: tb/tb_turn_signal_seq.sv
// Directed self-checking bench: a LAMPS=3/STEP_DIV=1 instance and a LAMPS=5/STEP_DIV=4 instance.
module tb_turn_signal_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b0, left_a = 1'b0, right_a = 1'b0, hazard_a = 1'b0, brake_a = 1'b0;
    logic [2:0] l_a, r_a;
    logic       rst_b = 1'b0, left_b = 1'b0, right_b = 1'b0, hazard_b = 1'b0, brake_b = 1'b0;
    logic [4:0] l_b, r_b;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    turn_signal_seq #(.LAMPS(3), .STEP_DIV(1)) dut_a (
        .clk(clk), .reset(rst_a), .left(left_a), .right(right_a), .hazard(hazard_a),
`ifdef TURN_SIGNAL_BRAKE_EN
        .brake(brake_a),
`endif
        .l(l_a), .r(r_a)
    );

    turn_signal_seq #(.LAMPS(5), .STEP_DIV(4)) dut_b (
        .clk(clk), .reset(rst_b), .left(left_b), .right(right_b), .hazard(hazard_b),
`ifdef TURN_SIGNAL_BRAKE_EN
        .brake(brake_b),
`endif
        .l(l_b), .r(r_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        chk_cnt++;
        if ({l_a, r_a} !== 6'b000000) $display("FAIL reset_a: got l=%b r=%b want 000/000", l_a, r_a);
        else pass_cnt++;
        chk_cnt++;
        if ({l_b, r_b} !== 10'b0) $display("FAIL reset_b: got l=%b r=%b want 0/0", l_b, r_b);
        else pass_cnt++;
    endtask

    task automatic test_left_sequence();
        logic [2:0] seq [4] = '{3'b001, 3'b011, 3'b111, 3'b000};
        step();
        rst_a  = 1'b1;
        left_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_cnt++;
            if (l_a !== seq[i % 4] || r_a !== 3'b000)
                $display("FAIL left_seq[%0d]: got l=%b r=%b want l=%b r=000", i, l_a, r_a, seq[i % 4]);
            else pass_cnt++;
        end
    endtask

    task automatic test_direction_change();
        logic [5:0] exp [4] = '{6'b000_001, 6'b000_011, 6'b000_000, 6'b001_000};
        left_a  = 1'b0;
        right_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                left_a  = 1'b1;
                right_a = 1'b0;
            end
            step();
            chk_cnt++;
            if ({l_a, r_a} !== exp[i])
                $display("FAIL dir_change[%0d]: got l=%b r=%b want %b", i, l_a, r_a, exp[i]);
            else pass_cnt++;
        end
        left_a = 1'b0;
        step();
    endtask

    task automatic test_hazard();
        logic [5:0] exp;
        left_a  = 1'b1;
        right_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            exp = (i % 2 == 0) ? 6'b111_111 : 6'b000_000;
            chk_cnt++;
            if ({l_a, r_a} !== exp)
                $display("FAIL haz_both[%0d]: got l=%b r=%b want %b", i, l_a, r_a, exp);
            else pass_cnt++;
        end
        left_a  = 1'b0;
        right_a = 1'b0;
        step();
        // hazard pin alone, then release must fall straight out of HAZ_ON
        hazard_a = 1'b1;
        step();
        chk_cnt++;
        if ({l_a, r_a} !== 6'b111_111) $display("FAIL haz_pin_on: got l=%b r=%b want 111/111", l_a, r_a);
        else pass_cnt++;
        hazard_a = 1'b0;
        step();
        chk_cnt++;
        if ({l_a, r_a} !== 6'b000_000) $display("FAIL haz_release: got l=%b r=%b want 000/000", l_a, r_a);
        else pass_cnt++;
        // hazard interrupting a left sequence
        left_a = 1'b1;
        step();
        hazard_a = 1'b1;
        step();
        chk_cnt++;
        if ({l_a, r_a} !== 6'b111_111) $display("FAIL haz_preempt: got l=%b r=%b want 111/111", l_a, r_a);
        else pass_cnt++;
        hazard_a = 1'b0;
        left_a   = 1'b0;
        step();
        left_a = 1'b1;
        step();
        chk_cnt++;
        if ({l_a, r_a} !== 6'b001_000) $display("FAIL haz_restart: got l=%b r=%b want 001/000", l_a, r_a);
        else pass_cnt++;
        left_a = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        left_a = 1'b1;
        step();
        step();
        chk_cnt++;
        if (l_a !== 3'b011) $display("FAIL pre_reset: got l=%b want 011", l_a);
        else pass_cnt++;
        #3 rst_a = 1'b0;
        #1;
        chk_cnt++;
        if ({l_a, r_a} !== 6'b000_000) $display("FAIL async_reset: got l=%b r=%b want 000/000", l_a, r_a);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (l_a !== 3'b000) $display("FAIL reset_hold: got l=%b want 000", l_a);
        else pass_cnt++;
        rst_a = 1'b1;
        step();
        chk_cnt++;
        if (l_a !== 3'b001) $display("FAIL reset_restart: got l=%b want 001", l_a);
        else pass_cnt++;
        left_a = 1'b0;
        step();
    endtask

    task automatic test_prescaler();
        logic [4:0] seq [6] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b00000};
        logic [4:0] exp;
        rst_b  = 1'b1;
        left_b = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            step();
            exp = (n < 4) ? 5'b00000 : seq[(n - 4) / 4];
            chk_cnt++;
            if (l_b !== exp || r_b !== 5'b00000)
                $display("FAIL div_seq[%0d]: got l=%b r=%b want l=%b", n, l_b, r_b, exp);
            else pass_cnt++;
        end
        // two-cycle pulse between ticks must be ignored
        for (int n = 25; n <= 28; n++) begin
            left_b = (n <= 26) ? 1'b1 : 1'b0;
            step();
            chk_cnt++;
            if (l_b !== 5'b00000) $display("FAIL div_pulse[%0d]: got l=%b want 00000", n, l_b);
            else pass_cnt++;
        end
        // request right after a tick waits a full period
        left_b = 1'b1;
        for (int n = 29; n <= 32; n++) begin
            step();
            exp = (n == 32) ? 5'b00001 : 5'b00000;
            chk_cnt++;
            if (l_b !== exp) $display("FAIL div_latency[%0d]: got l=%b want %b", n, l_b, exp);
            else pass_cnt++;
        end
        left_b = 1'b0;
    endtask

`ifdef TURN_SIGNAL_BRAKE_EN
    task automatic test_brake();
        logic [5:0] exp [4] = '{6'b001_111, 6'b011_111, 6'b111_111, 6'b111_111};
        brake_a = 1'b1;
        #1;
        chk_cnt++;
        if ({l_a, r_a} !== 6'b111_111) $display("FAIL brake_idle: got l=%b r=%b want 111/111", l_a, r_a);
        else pass_cnt++;
        left_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_cnt++;
            if ({l_a, r_a} !== exp[i])
                $display("FAIL brake_left[%0d]: got l=%b r=%b want %b", i, l_a, r_a, exp[i]);
            else pass_cnt++;
        end
        left_a   = 1'b0;
        hazard_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_cnt++;
            if ({l_a, r_a} !== ((i % 2 == 0) ? 6'b111_111 : 6'b000_000))
                $display("FAIL brake_haz[%0d]: got l=%b r=%b", i, l_a, r_a);
            else pass_cnt++;
        end
        hazard_a = 1'b0;
        brake_a  = 1'b0;
        step();
        chk_cnt++;
        if ({l_a, r_a} !== 6'b000_000) $display("FAIL brake_off: got l=%b r=%b want 000/000", l_a, r_a);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_left_sequence();
        test_direction_change();
        test_hazard();
        test_async_reset();
        test_prescaler();
`ifdef TURN_SIGNAL_BRAKE_EN
        test_brake();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
